hwag_sync_ctrl: RTL and testbench
=================================

HWAG_SYNC_CTRL -- requirements
Module: hwag_sync_ctrl

Interface
REQ-001 The block SHALL have parameter TEETH, default 58, meaning physical teeth per crank revolution (60-2 wheel).
REQ-002 The block SHALL have parameter PER_W, default 20, meaning the tooth-period timer width in bits.
REQ-003 The block SHALL have parameter VERIFY_REVS, default 1, meaning the number of consecutive clean revolutions required before lock.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port cap, input, 1 bit: the asynchronous VR comparator output; a tooth is its rising edge.
REQ-007 The block SHALL have port cam, input, 1 bit: the asynchronous cam sensor level.
REQ-008 The block SHALL have port tooth_edge, output, 1 bit: a 1-cycle pulse per qualified tooth edge.
REQ-009 The block SHALL have port tooth_num, output, 6 bits: the current tooth index, 0..TEETH-1.
REQ-010 The block SHALL have port tooth_period, output, PER_W bits: the last measured edge-to-edge period in clk cycles.
REQ-011 The block SHALL have port synced, output, 1 bit: crank position locked.
REQ-012 The block SHALL have port hwag_start, output, 1 bit: a 1-cycle pulse at tooth 0 while synced, used to start/realign the angle generator.
REQ-013 The block SHALL have port cam_phase, output, 1 bit: the cam level sampled at the last gap (0/1 selects the 360-degree half of the cycle).
REQ-014 The block SHALL have port sync_err, output, 1 bit: a 1-cycle pulse on loss of sync.

Function
REQ-015 cap and cam SHALL each pass a 2-FF synchronizer; a rising edge SHALL be detected on the synchronized cap, and tooth_edge SHALL assert exactly 3 clk cycles after the cap transition is captured by the first FF.
REQ-016 The period timer SHALL increment every cycle, saturate at 2^PER_W-1, and be cleared to 1 on each detected edge; tooth_period and an internal prev_period SHALL be loaded at the edge (prev_period <= old tooth_period).
REQ-017 An edge SHALL be classified as a gap when the period just measured > 2*prev_period, with 2*prev_period computed at PER_W+1 bits (no overflow); classification SHALL be valid only when prev_period is nonzero.
REQ-018 The FSM SHALL have states IDLE, WAIT_GAP, VERIFY and SYNCED.
REQ-019 IDLE -> WAIT_GAP SHALL occur on the first edge.
REQ-020 WAIT_GAP -> VERIFY SHALL occur on a gap edge; tooth_num SHALL be set to 0 and the revolution counter cleared.
REQ-021 In VERIFY, a non-gap edge SHALL increment tooth_num.
REQ-022 In VERIFY, a gap edge with tooth_num==TEETH-1 SHALL increment the revolution counter; when that counter reaches VERIFY_REVS the FSM SHALL enter SYNCED and assert hwag_start on the same cycle; otherwise it SHALL stay in VERIFY with tooth_num=0.
REQ-023 In VERIFY, a gap edge at any other tooth, or a non-gap edge when tooth_num==TEETH-1, SHALL return the FSM to WAIT_GAP with no sync_err pulse.
REQ-024 In SYNCED, a non-gap edge with tooth_num<TEETH-1 SHALL increment tooth_num.
REQ-025 In SYNCED, a gap edge with tooth_num==TEETH-1 SHALL set tooth_num to 0 and pulse hwag_start.
REQ-026 In SYNCED, any other gap/count mismatch SHALL pulse sync_err, clear synced, and enter WAIT_GAP.
REQ-027 Stall: timer saturation in any state except IDLE SHALL force IDLE and clear prev_period and tooth_period to 0, with a sync_err pulse if the FSM was SYNCED.
REQ-028 synced SHALL be high exactly while the state is SYNCED, registered and updated on the same edge as the state.
REQ-029 cam_phase SHALL load the synchronized cam on every gap edge in VERIFY and SYNCED.
REQ-030 tooth_num SHALL hold its value in IDLE and WAIT_GAP.
REQ-031 An edge coincident with timer saturation SHALL be processed as an edge (the edge takes priority) and the stall SHALL be ignored.

Reset
REQ-032 While rst=0, all outputs and state SHALL be 0, the state SHALL be IDLE, and the synchronizers and timer SHALL be cleared.
REQ-033 Reset SHALL take effect asynchronously, including mid-revolution and while SYNCED, with no sync_err pulse.
REQ-034 Release SHALL be synchronous to clk, and the first edge after release SHALL only enter WAIT_GAP.

Verification
REQ-035 Constant wheel, 128-cycle tooth, gap 384 cycles, VERIFY_REVS=1 -> synced rises with hwag_start at tooth 0 after the 2nd gap; tooth_num counts 0..57; hwag_start occurs every 58 edges.
REQ-036 Gradual acceleration (period -1 per revolution) -> no sync_err, tooth_period tracks, and synced stays 1.
REQ-037 While synced, remove one tooth at tooth 20 -> sync_err pulse, synced=0, FSM re-locks after 2 further gaps.
REQ-038 Stop cap for 2^20 cycles while synced -> sync_err, IDLE, tooth_period=0; re-lock on restart.
REQ-039 cam low from tooth 54 to tooth 4 on alternate revolutions -> cam_phase toggles on each gap.
REQ-040 Assert rst mid-revolution while synced -> all outputs 0 immediately; no hwag_start until re-verified.

Source files
------------

// File: rtl/hwag_sync_ctrl.sv
// hwag_sync_ctrl: crank-wheel synchronisation for a 60-2 style trigger wheel.
// Qualifies VR comparator edges, measures tooth periods, finds the missing-tooth
// gap, verifies whole revolutions and then tracks tooth position, flagging any
// loss of sync. Cam level is latched at each gap to select the engine-cycle half.
//
// Ports
//   clk           : rising-edge clock
//   rst           : asynchronous active-low reset
//   cap           : asynchronous VR comparator output (tooth = rising edge)
//   cam           : asynchronous cam sensor level
//   tooth_edge    : 1-cycle pulse per qualified tooth edge
//   tooth_num     : current tooth index, 0..TEETH-1
//   tooth_period  : last edge-to-edge period in clk cycles
//   synced        : crank position locked
//   hwag_start    : 1-cycle pulse at tooth 0 while synced
//   cam_phase     : synchronised cam level sampled at the last gap
//   sync_err      : 1-cycle pulse on loss of sync
module hwag_sync_ctrl #(
    parameter int unsigned TEETH       = 58,
    parameter int unsigned PER_W       = 20,
    parameter int unsigned VERIFY_REVS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cap,
    input  logic             cam,
    output logic             tooth_edge,
    output logic [5:0]       tooth_num,
    output logic [PER_W-1:0] tooth_period,
    output logic             synced,
    output logic             hwag_start,
    output logic             cam_phase,
    output logic             sync_err
);

    localparam int unsigned TN_W  = 6;
    localparam int unsigned REV_W = (VERIFY_REVS < 2) ? 1 : $clog2(VERIFY_REVS + 1);

    localparam logic [TN_W-1:0]  LAST_TOOTH = TN_W'(TEETH - 1);
    localparam logic [REV_W-1:0] REV_TARGET = REV_W'(VERIFY_REVS);
    localparam logic [PER_W-1:0] TIMER_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_GAP = 2'd1,
        VERIFY   = 2'd2,
        SYNCED   = 2'd3
    } state_t;

    state_t state, state_nx;

    // Synchroniser and edge-detect pipeline
    logic cap_s1, cap_s2, cap_s3;
    logic cam_s1, cam_s2;
    logic edge_q;

    // Period measurement
    logic [PER_W-1:0] timer;
    logic [PER_W-1:0] prev_period, prev_period_nx;
    logic [PER_W-1:0] tooth_period_nx;
    logic [PER_W:0]   prev_x2;
    logic             is_gap;
    logic             stall;

    // Revolution verification and registered-output next values
    logic [REV_W-1:0] rev_cnt, rev_cnt_nx, rev_inc;
    logic [TN_W-1:0]  tooth_num_nx;
    logic             hwag_start_nx;
    logic             sync_err_nx;
    logic             cam_phase_nx;

    // Two-flop synchronisers; third cap flop gives the previous level for edge detect
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cap_s1 <= 1'b0;
            cap_s2 <= 1'b0;
            cap_s3 <= 1'b0;
            cam_s1 <= 1'b0;
            cam_s2 <= 1'b0;
            edge_q <= 1'b0;
        end else begin
            cap_s1 <= cap;
            cap_s2 <= cap_s1;
            cap_s3 <= cap_s2;
            cam_s1 <= cam;
            cam_s2 <= cam_s1;
            edge_q <= cap_s2 & ~cap_s3;
        end
    end

    // Free-running period timer: restarts at 1 on an edge, saturates when the wheel stops
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer <= '0;
        end else if (edge_q) begin
            timer <= PER_W'(1);
        end else if (timer != TIMER_MAX) begin
            timer <= timer + PER_W'(1);
        end
    end

    // Gap test at one extra bit so doubling never wraps; needs a valid reference period
    assign prev_x2 = {prev_period, 1'b0};
    assign is_gap  = (prev_period != '0) && ({1'b0, timer} > prev_x2);

    // A coincident edge wins over saturation
    assign stall   = (timer == TIMER_MAX) && (state != IDLE) && !edge_q;

    assign rev_inc = rev_cnt + REV_W'(1);

    // Next-state and next-output logic
    always_comb begin
        state_nx        = state;
        tooth_num_nx    = tooth_num;
        rev_cnt_nx      = rev_cnt;
        hwag_start_nx   = 1'b0;
        sync_err_nx     = 1'b0;
        cam_phase_nx    = cam_phase;
        tooth_period_nx = tooth_period;
        prev_period_nx  = prev_period;

        if (edge_q) begin
            tooth_period_nx = timer;
            prev_period_nx  = tooth_period;

            if (is_gap && ((state == VERIFY) || (state == SYNCED))) begin
                cam_phase_nx = cam_s2;
            end

            case (state)
                IDLE: begin
                    state_nx = WAIT_GAP;
                end
                WAIT_GAP: begin
                    if (is_gap) begin
                        state_nx     = VERIFY;
                        tooth_num_nx = '0;
                        rev_cnt_nx   = '0;
                    end
                end
                VERIFY: begin
                    if (is_gap) begin
                        if (tooth_num == LAST_TOOTH) begin
                            tooth_num_nx = '0;
                            if (rev_inc == REV_TARGET) begin
                                state_nx      = SYNCED;
                                hwag_start_nx = 1'b1;
                                rev_cnt_nx    = '0;
                            end else begin
                                rev_cnt_nx = rev_inc;
                            end
                        end else begin
                            // Misplaced gap while still verifying: quietly restart the search
                            state_nx = WAIT_GAP;
                        end
                    end else if (tooth_num == LAST_TOOTH) begin
                        state_nx = WAIT_GAP;
                    end else begin
                        tooth_num_nx = tooth_num + TN_W'(1);
                    end
                end
                SYNCED: begin
                    if (is_gap && (tooth_num == LAST_TOOTH)) begin
                        tooth_num_nx  = '0;
                        hwag_start_nx = 1'b1;
                    end else if (!is_gap && (tooth_num < LAST_TOOTH)) begin
                        tooth_num_nx = tooth_num + TN_W'(1);
                    end else begin
                        state_nx    = WAIT_GAP;
                        sync_err_nx = 1'b1;
                    end
                end
                default: begin
                    state_nx = IDLE;
                end
            endcase
        end else if (stall) begin
            // Wheel stopped: drop back to IDLE and forget the period history
            state_nx        = IDLE;
            tooth_period_nx = '0;
            prev_period_nx  = '0;
            sync_err_nx     = (state == SYNCED);
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Registered outputs and datapath state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tooth_edge   <= 1'b0;
            tooth_num    <= '0;
            tooth_period <= '0;
            prev_period  <= '0;
            rev_cnt      <= '0;
            synced       <= 1'b0;
            hwag_start   <= 1'b0;
            cam_phase    <= 1'b0;
            sync_err     <= 1'b0;
        end else begin
            tooth_edge   <= edge_q;
            tooth_num    <= tooth_num_nx;
            tooth_period <= tooth_period_nx;
            prev_period  <= prev_period_nx;
            rev_cnt      <= rev_cnt_nx;
            synced       <= (state_nx == SYNCED);
            hwag_start   <= hwag_start_nx;
            cam_phase    <= cam_phase_nx;
            sync_err     <= sync_err_nx;
        end
    end

endmodule

// File: tb/tb_hwag_sync_ctrl.sv
// Directed bench for hwag_sync_ctrl: a 60-2 wheel is synthesised tooth by tooth;
// each driven rising edge pushes its expected outputs to a queue, and a monitor
// pops and compares when the DUT reports tooth_edge.
module tb_hwag_sync_ctrl;

    localparam int T   = 58;
    localparam int PW  = 12;
    localparam int P   = 32;
    localparam int HI  = 8;
    localparam int DC  = -1;
    localparam int LAT = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cap;
    logic          cam;
    logic          tooth_edge;
    logic [5:0]    tooth_num;
    logic [PW-1:0] tooth_period;
    logic          synced;
    logic          hwag_start;
    logic          cam_phase;
    logic          sync_err;

    hwag_sync_ctrl #(
        .TEETH       (T),
        .PER_W       (PW),
        .VERIFY_REVS (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cap          (cap),
        .cam          (cam),
        .tooth_edge   (tooth_edge),
        .tooth_num    (tooth_num),
        .tooth_period (tooth_period),
        .synced       (synced),
        .hwag_start   (hwag_start),
        .cam_phase    (cam_phase),
        .sync_err     (sync_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int tnum;
        int tper;
        int syn;
        int hs;
        int err;
        int cph;
        int stamp;
    } exp_t;

    exp_t q[$];
    int   checks  = 0;
    int   errors  = 0;
    int   cyc     = 0;
    int   hs_cnt  = 0;
    int   err_cnt = 0;
    logic cam_lo  = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input int tnum, input int tper, input int syn,
                                input int hs, input int err, input int cph);
        exp_t e;
        e.tnum  = tnum;
        e.tper  = tper;
        e.syn   = syn;
        e.hs    = hs;
        e.err   = err;
        e.cph   = cph;
        e.stamp = 0;
        return e;
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One tooth: low for per-HI cycles, rising edge, high for HI cycles
    task automatic pulse(input int per, input exp_t e);
        exp_t en;
        en = e;
        wait_cyc(per - HI);
        cap      = 1'b1;
        en.stamp = cyc;
        q.push_back(en);
        wait_cyc(HI);
        cap = 1'b0;
    endtask

    // Physical teeth from..to; counted teeth expect i-toff, otherwise a held index
    task automatic teeth(input int from, input int to, input int per, input int syn,
                         input bit cnt, input int toff, input int thold);
        for (int i = from; i <= to; i++) begin
            if (i == 54) cam = cam_lo;
            else if (i == 5) cam = 1'b1;
            pulse(per, mk(cnt ? (i - toff) : thold, per, syn, 0, 0, DC));
        end
    endtask

    task automatic gap(input int per, input int tn, input int syn, input int hs,
                       input int err, input int cph);
        pulse(3 * per, mk(tn, 3 * per, syn, hs, err, cph));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_tooth_edge"},   32'(tooth_edge),   0);
        chk({tag, "_tooth_num"},    32'(tooth_num),    0);
        chk({tag, "_tooth_period"}, 32'(tooth_period), 0);
        chk({tag, "_synced"},       32'(synced),       0);
        chk({tag, "_hwag_start"},   32'(hwag_start),   0);
        chk({tag, "_cam_phase"},    32'(cam_phase),    0);
        chk({tag, "_sync_err"},     32'(sync_err),     0);
    endtask

    // Cycle counter
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Pulse counters for events that can happen without a tooth edge
    initial forever begin
        @(negedge clk);
        if (hwag_start === 1'b1) hs_cnt++;
        if (sync_err === 1'b1) err_cnt++;
    end

    // Scoreboard monitor
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (rst === 1'b1 && tooth_edge === 1'b1) begin
            chk("edge_expected", 32'(q.size() != 0), 1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("edge_latency", cyc - e.stamp, LAT);
                if (e.tnum != DC) chk("tooth_num",    32'(tooth_num),    e.tnum);
                if (e.tper != DC) chk("tooth_period", 32'(tooth_period), e.tper);
                if (e.syn  != DC) chk("synced",       32'(synced),       e.syn);
                if (e.hs   != DC) chk("hwag_start",   32'(hwag_start),   e.hs);
                if (e.err  != DC) chk("sync_err",     32'(sync_err),     e.err);
                if (e.cph  != DC) chk("cam_phase",    32'(cam_phase),    e.cph);
            end
        end
    end

    initial begin
        int err0;
        int hs0;

        rst = 1'b0;
        cap = 1'b0;
        cam = 1'b1;
        wait_cyc(5);
        check_all_zero("reset");
        rst = 1'b1;

        // Spin-up: first edge only leaves IDLE, then search for the gap
        pulse(200, mk(0, DC, 0, 0, 0, DC));
        teeth(49, 57, P, 0, 1'b0, 0, 0);
        gap(P, 0, 0, 0, 0, DC);
        // One verified revolution, lock with hwag_start on the second gap
        teeth(1, 57, P, 0, 1'b1, 0, 0);
        gap(P, 0, 1, 1, 0, int'(cam));

        // Synced revolutions with cam low around the gap on alternate revolutions
        for (int r = 0; r < 4; r++) begin
            cam_lo = (r % 2 == 1);
            teeth(1, 57, P, 1, 1'b1, 0, 0);
            gap(P, 0, 1, 1, 0, int'(cam));
        end
        cam_lo = 1'b1;

        // Gradual acceleration: one cycle shorter per revolution
        for (int k = 1; k <= 4; k++) begin
            teeth(1, 57, P - k, 1, 1'b1, 0, 0);
            gap(P - k, 0, 1, 1, 0, int'(cam));
        end

        // Missing tooth 20 while synced
        err0 = err_cnt;
        teeth(1, 19, P, 1, 1'b1, 0, 0);
        pulse(2 * P, mk(20, 2 * P, 1, 0, 0, DC));
        teeth(22, 57, P, 1, 1'b1, 1, 0);
        gap(P, DC, 0, 0, 1, DC);
        teeth(1, 57, P, 0, 1'b0, 0, DC);
        gap(P, 0, 0, 0, 0, DC);
        teeth(1, 57, P, 0, 1'b1, 0, 0);
        gap(P, 0, 1, 1, 0, int'(cam));
        chk("missing_tooth_err_count", err_cnt - err0, 1);

        // Stall while synced, then restart
        teeth(1, 10, P, 1, 1'b1, 0, 0);
        err0 = err_cnt;
        hs0  = hs_cnt;
        wait_cyc(4400);
        chk("stall_err_count",    err_cnt - err0, 1);
        chk("stall_synced",       32'(synced), 0);
        chk("stall_tooth_period", 32'(tooth_period), 0);
        chk("stall_tooth_num",    32'(tooth_num), 10);
        pulse(P, mk(10, (1 << PW) - 1, 0, 0, 0, DC));
        teeth(12, 57, P, 0, 1'b0, 0, 10);
        gap(P, 0, 0, 0, 0, DC);
        teeth(1, 57, P, 0, 1'b1, 0, 0);
        gap(P, 0, 1, 1, 0, int'(cam));
        chk("stall_relock_hs_count", hs_cnt - hs0, 1);

        // Asynchronous reset mid-revolution while synced
        teeth(1, 30, P, 1, 1'b1, 0, 0);
        wait_cyc(3);
        err0 = err_cnt;
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("async_reset");
        wait_cyc(5);
        chk("async_reset_no_err", err_cnt - err0, 0);
        rst = 1'b1;
        hs0 = hs_cnt;
        pulse(200, mk(0, DC, 0, 0, 0, DC));
        teeth(32, 57, P, 0, 1'b0, 0, 0);
        gap(P, 0, 0, 0, 0, DC);
        teeth(1, 57, P, 0, 1'b1, 0, 0);
        gap(P, 0, 1, 1, 0, int'(cam));
        chk("reset_relock_hs_count", hs_cnt - hs0, 1);

        wait_cyc(10);
        chk("scoreboard_drained", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
